// File: rtl/pmod_dac_ser.sv
// Lockstep serialiser for N_CH DAC lanes: one chip select and one sclk shared by all lanes, MSB-first frames.
// Define PMOD_DAC_PD_EN to add pd_mode, which is carried in the last two lead bits of every frame.
module pmod_dac_ser #(
   parameter int N_CH      = 2,
   parameter int DATA_W    = 12,
   parameter int LEAD_BITS = 4,
   parameter int CLK_DIV   = 1,
   parameter int GAP_CYC   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [N_CH*DATA_W-1:0]   data_in,
`ifdef PMOD_DAC_PD_EN
   input  logic [1:0]               pd_mode,
`endif
   output logic                     ready,
   output logic                     done,
   output logic                     cs,
   output logic                     sclk,
   output logic [N_CH-1:0]          din
);

   localparam int FRAME_W = LEAD_BITS + DATA_W;
   localparam int BIT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
   localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYC - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;

`ifdef PMOD_DAC_PD_EN
   generate
      if (LEAD_BITS < 2) begin : gLeadCheck
         $error("pmod_dac_ser: LEAD_BITS must be at least 2 when power-down bits are carried");
      end
   endgenerate
`endif

   logic [1:0]                     state_q, state_d;
   logic [DIV_W-1:0]               divCnt_q, divCnt_d;
   logic                           lowHalf_q, lowHalf_d;
   logic [BIT_W-1:0]               bitCnt_q, bitCnt_d;
   logic [GAP_W-1:0]               gapCnt_q, gapCnt_d;
   logic                           cs_q, cs_d;
   logic                           sclk_q, sclk_d;
   logic [N_CH-1:0]                din_q, din_d;
   logic [N_CH-1:0][FRAME_W-1:0]   shiftReg_q, shiftReg_d;
   logic [N_CH-1:0][FRAME_W-1:0]   loadFrame;
   logic                           accept;

   // Done and ready are raised during the last gap cycle so that a start seen
   // on that edge begins the next frame with exactly GAP_CYC cycles of cs high.
   assign done   = (state_q == GAP) && (gapCnt_q == LAST_GAP);
   assign ready  = (state_q == IDLE) || done;
   assign accept = start && ready;

   assign cs   = cs_q;
   assign sclk = sclk_q;
   assign din  = din_q;

   always_comb begin
      loadFrame = '0;
      for (int k = 0; k < N_CH; k++) begin
         loadFrame[k][DATA_W-1:0] = data_in[k*DATA_W +: DATA_W];
`ifdef PMOD_DAC_PD_EN
         loadFrame[k][DATA_W +: 2] = pd_mode;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      divCnt_d   = divCnt_q;
      lowHalf_d  = lowHalf_q;
      bitCnt_d   = bitCnt_q;
      gapCnt_d   = gapCnt_q;
      cs_d       = cs_q;
      sclk_d     = sclk_q;
      din_d      = din_q;
      shiftReg_d = shiftReg_q;

      case (state_q)
         SHIFT: begin
            if (divCnt_q == LAST_DIV) begin
               divCnt_d = '0;
               if (!lowHalf_q) begin
                  lowHalf_d = 1'b1;
                  sclk_d    = 1'b0;
               end else begin
                  lowHalf_d = 1'b0;
                  sclk_d    = 1'b1;
                  if (bitCnt_q == LAST_BIT) begin
                     state_d  = GAP;
                     cs_d     = 1'b1;
                     din_d    = '0;
                     bitCnt_d = '0;
                     gapCnt_d = '0;
                  end else begin
                     bitCnt_d = bitCnt_q + 1'b1;
                     for (int k = 0; k < N_CH; k++) begin
                        din_d[k]      = shiftReg_q[k][FRAME_W-1];
                        shiftReg_d[k] = shiftReg_q[k] << 1;
                     end
                  end
               end
            end else begin
               divCnt_d = divCnt_q + 1'b1;
            end
         end
         GAP: begin
            if (gapCnt_q == LAST_GAP) begin
               state_d  = IDLE;
               gapCnt_d = '0;
            end else begin
               gapCnt_d = gapCnt_q + 1'b1;
            end
         end
         IDLE:    ;
         default: state_d = IDLE;
      endcase

      // Accepting overrides the gap bookkeeping; the first bit goes out with sclk still high.
      if (accept) begin
         state_d   = SHIFT;
         cs_d      = 1'b0;
         sclk_d    = 1'b1;
         divCnt_d  = '0;
         lowHalf_d = 1'b0;
         bitCnt_d  = '0;
         gapCnt_d  = '0;
         for (int k = 0; k < N_CH; k++) begin
            din_d[k]      = loadFrame[k][FRAME_W-1];
            shiftReg_d[k] = loadFrame[k] << 1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         divCnt_q   <= '0;
         lowHalf_q  <= 1'b0;
         bitCnt_q   <= '0;
         gapCnt_q   <= '0;
         cs_q       <= 1'b1;
         sclk_q     <= 1'b1;
         din_q      <= '0;
         shiftReg_q <= '0;
      end else begin
         state_q    <= state_d;
         divCnt_q   <= divCnt_d;
         lowHalf_q  <= lowHalf_d;
         bitCnt_q   <= bitCnt_d;
         gapCnt_q   <= gapCnt_d;
         cs_q       <= cs_d;
         sclk_q     <= sclk_d;
         din_q      <= din_d;
         shiftReg_q <= shiftReg_d;
      end
   end

endmodule

// File: tb/tb_pmod_dac_ser.sv
// Bench for pmod_dac_ser: a default instance (A) and a CLK_DIV=3, 4-lane, 8-bit instance (B),
// with a lane-capturing monitor that checks every frame against a scoreboard of expected frames.
module tb_pmod_dac_ser;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        startA = 1'b0;
   logic [23:0] dataA  = '0;
   logic        readyA, doneA, csA, sclkA;
   logic [1:0]  dinA;
`ifdef PMOD_DAC_PD_EN
   logic [1:0]  pdA = 2'b00;
   logic [1:0]  pdB = 2'b00;
   localparam logic [1:0] PD_MASK = 2'b11;
`else
   localparam logic [1:0] PD_MASK = 2'b00;
`endif

   logic        startB = 1'b0;
   logic [31:0] dataB  = '0;
   logic        readyB, doneB, csB, sclkB;
   logic [3:0]  dinB;

   int nCompared   = 0;
   int nMismatched = 0;

   logic [63:0] qA[$];
   logic [63:0] qB[$];

   always #5 clk = ~clk;

   pmod_dac_ser dutA (
      .clk     (clk),
      .rst     (rst),
      .start   (startA),
      .data_in (dataA),
`ifdef PMOD_DAC_PD_EN
      .pd_mode (pdA),
`endif
      .ready   (readyA),
      .done    (doneA),
      .cs      (csA),
      .sclk    (sclkA),
      .din     (dinA)
   );

   pmod_dac_ser #(.N_CH(4), .DATA_W(8), .LEAD_BITS(4), .CLK_DIV(3), .GAP_CYC(2)) dutB (
      .clk     (clk),
      .rst     (rst),
      .start   (startB),
      .data_in (dataB),
`ifdef PMOD_DAC_PD_EN
      .pd_mode (pdB),
`endif
      .ready   (readyB),
      .done    (doneB),
      .cs      (csB),
      .sclk    (sclkB),
      .din     (dinB)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // Lane k of instance A is a 16-bit frame: four lead bits (pd in the lowest two) then the 12-bit sample.
   function automatic logic [63:0] expFrameA(input logic [23:0] data, input logic [1:0] pd);
      logic [15:0] lane0, lane1;
      lane0 = {2'b00, pd & PD_MASK, data[11:0]};
      lane1 = {2'b00, pd & PD_MASK, data[23:12]};
      return {32'h0, lane1, lane0};
   endfunction

   function automatic logic [63:0] expFrameB(input logic [31:0] data);
      return {8'h00, data[31:24], 8'h00, data[23:16], 8'h00, data[15:8], 8'h00, data[7:0]};
   endfunction

   task automatic applyStimulus(input int inst, input logic [31:0] data, input logic [1:0] pd);
      if (inst == 0) begin
         dataA  = data[23:0];
`ifdef PMOD_DAC_PD_EN
         pdA    = pd;
`endif
         startA = 1'b1;
         qA.push_back(expFrameA(data[23:0], pd));
      end else begin
         dataB  = data;
         startB = 1'b1;
         qB.push_back(expFrameB(data));
      end
   endtask

   // Called at the negedge before the accept edge; k counts negedges after that edge.
   task automatic waitDone(input int inst, input int pulseAt, output int lat,
                           output logic csFirst, output logic readyFirst);
      lat = 0;
      csFirst = 1'bx;
      readyFirst = 1'bx;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (k == 1) begin
            startA = 1'b0;
            startB = 1'b0;
            csFirst    = (inst == 0) ? csA : csB;
            readyFirst = (inst == 0) ? readyA : readyB;
         end
         if (k == pulseAt) begin
            if (inst == 0) begin startA = 1'b1; dataA = ~dataA; end
            else begin startB = 1'b1; dataB = ~dataB; end
         end
         if (k == pulseAt + 1) begin
            startA = 1'b0;
            startB = 1'b0;
         end
         if ((inst == 0) ? doneA : doneB) begin
            lat = k;
            break;
         end
      end
   endtask

   logic [3:0]  dinV [2];
   logic [1:0]  csV, sclkV;
   always_comb begin
      dinV[0] = {2'b00, dinA};
      dinV[1] = dinB;
      csV     = {csB, csA};
      sclkV   = {sclkB, sclkA};
   end

   logic [15:0] cap [2][4];
   int          falls [2];
   int          lowCyc [2];
   int          runLen [2];
   int          badRuns [2];
   logic [1:0]  prevCs   = 2'b11;
   logic [1:0]  prevSclk = 2'b11;
   int          divM, frameM;
   string       pfx;
   logic [63:0] expM;

   // Samples each lane on falling sclk while cs is low and scores the frame when cs rises.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         divM   = (i == 0) ? 1 : 3;
         frameM = (i == 0) ? 16 : 12;
         pfx    = (i == 0) ? "A" : "B";
         if (rst) begin
            prevCs[i]   = 1'b1;
            prevSclk[i] = 1'b1;
         end else begin
            if (!csV[i]) begin
               if (prevCs[i]) begin
                  for (int l = 0; l < 4; l++) cap[i][l] = '0;
                  falls[i] = 0; lowCyc[i] = 0; runLen[i] = 0; badRuns[i] = 0;
               end
               lowCyc[i]++;
               if (runLen[i] == 0) runLen[i] = 1;
               else if (sclkV[i] == prevSclk[i]) runLen[i]++;
               else begin
                  if (runLen[i] != divM) badRuns[i]++;
                  runLen[i] = 1;
               end
               if (prevSclk[i] && !sclkV[i] && !prevCs[i]) begin
                  for (int l = 0; l < 4; l++) cap[i][l] = {cap[i][l][14:0], dinV[i][l]};
                  falls[i]++;
               end
            end else if (!prevCs[i]) begin
               if (runLen[i] != divM) badRuns[i]++;
               checkOutput({pfx, ".frameExpected"}, 64'((i == 0) ? (qA.size() != 0) : (qB.size() != 0)), 64'd1);
               expM = '0;
               if (i == 0 && qA.size() != 0) expM = qA.pop_front();
               if (i == 1 && qB.size() != 0) expM = qB.pop_front();
               checkOutput({pfx, ".laneData"}, {cap[i][3], cap[i][2], cap[i][1], cap[i][0]}, expM);
               checkOutput({pfx, ".sclkFalls"}, 64'(falls[i]), 64'(frameM));
               checkOutput({pfx, ".csLowCycles"}, 64'(lowCyc[i]), 64'(frameM * 2 * divM));
               checkOutput({pfx, ".badSclkHalves"}, 64'(badRuns[i]), 64'd0);
               checkOutput({pfx, ".idleLines"}, 64'({sclkV[i], dinV[i]}), 64'h10);
            end
            prevCs[i]   = csV[i];
            prevSclk[i] = sclkV[i];
         end
      end
   end

   initial begin
      int   lat, nDone, csRun;
      logic c1, r1, prevC;

      $display("[TB] reset");
      repeat (3) @(negedge clk);
      checkOutput("rst.readyA", 64'(readyA), 64'd1);
      checkOutput("rst.csA",    64'(csA),    64'd1);
      checkOutput("rst.sclkA",  64'(sclkA),  64'd1);
      checkOutput("rst.dinA",   64'(dinA),   64'd0);
      checkOutput("rst.doneA",  64'(doneA),  64'd0);
      checkOutput("rst.readyB", 64'(readyB), 64'd1);
      checkOutput("rst.csB",    64'(csB),    64'd1);

      $display("[TB] first frame right after reset release, with an ignored mid-frame start");
      rst = 1'b0;
      applyStimulus(0, 32'h00A5C3F1, 2'b00);
      waitDone(0, 10, lat, c1, r1);
      checkOutput("A.latency",      64'(lat), 64'd33);
      checkOutput("A.csAtAccept",   64'(c1),  64'd0);
      checkOutput("A.readyBusy",    64'(r1),  64'd0);
      checkOutput("A.readyAtDone",  64'(readyA), 64'd1);
      repeat (3) @(negedge clk);
      checkOutput("A.notQueuedCs",    64'(csA),    64'd1);
      checkOutput("A.notQueuedReady", 64'(readyA), 64'd1);

      $display("[TB] power-down code in lead bits");
      applyStimulus(0, 32'h00123456, 2'b10);
      waitDone(0, 0, lat, c1, r1);
      checkOutput("A.pdLatency", 64'(lat), 64'd33);
      @(negedge clk);

      $display("[TB] start held high for three frames");
      nDone = 0; csRun = 0; prevC = 1'b0;
      applyStimulus(0, 32'h00FFF000, 2'b00);
      for (int k = 0; k < 200 && nDone < 3; k++) begin
         @(negedge clk);
         if (csA) csRun++;
         if (!csA && prevC) begin
            checkOutput("A.csGap", 64'(csRun), 64'd1);
            csRun = 0;
         end
         prevC = csA;
         if (doneA) begin
            nDone++;
            if (nDone == 1) begin dataA = 24'h0017E8; qA.push_back(expFrameA(24'h0017E8, 2'b00)); end
            if (nDone == 2) begin dataA = 24'h800001; qA.push_back(expFrameA(24'h800001, 2'b00)); end
            if (nDone == 3) startA = 1'b0;
         end
      end
      checkOutput("A.b2bDones", 64'(nDone), 64'd3);
      repeat (2) @(negedge clk);

      $display("[TB] reset during bit 7, then start held through reset");
      applyStimulus(0, 32'h00ABCDEF, 2'b00);
      @(negedge clk);
      startA = 1'b0;
      repeat (14) @(negedge clk);
      rst = 1'b1;
      qA.delete(qA.size() - 1);
      @(negedge clk);
      checkOutput("abort.cs",    64'(csA),    64'd1);
      checkOutput("abort.sclk",  64'(sclkA),  64'd1);
      checkOutput("abort.din",   64'(dinA),   64'd0);
      checkOutput("abort.ready", 64'(readyA), 64'd1);
      checkOutput("abort.done",  64'(doneA),  64'd0);
      applyStimulus(0, 32'h00654321, 2'b00);
      @(negedge clk);
      checkOutput("rstDominates.cs", 64'(csA), 64'd1);
      rst = 1'b0;
      waitDone(0, 0, lat, c1, r1);
      checkOutput("A.afterRstCs",      64'(c1),  64'd0);
      checkOutput("A.afterRstLatency", 64'(lat), 64'd33);
      @(negedge clk);

      $display("[TB] instance B: divided sclk, four lanes, two-cycle gap");
      applyStimulus(1, 32'hC35A0F81, 2'b00);
      waitDone(1, 20, lat, c1, r1);
      checkOutput("B.latency",    64'(lat), 64'd74);
      checkOutput("B.csAtAccept", 64'(c1),  64'd0);
      repeat (4) @(negedge clk);

      checkOutput("scoreboardEmpty", 64'(qA.size() + qB.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/pmod_dac_ser.md
PMOD_DAC_SER -- requirements
Module: pmod_dac_ser

Interface
REQ-001 Parameter N_CH, default 2, number of DAC channels serialised in lockstep (1..8).
REQ-002 Parameter DATA_W, default 12, sample width per channel (1..16).
REQ-003 Parameter LEAD_BITS, default 4, leading control/padding bits per frame (0..8).
REQ-004 Parameter CLK_DIV, default 1, clk cycles per sclk half-period (1..255).
REQ-005 Parameter GAP_CYC, default 1, cs-high cycles between frames (1..255).
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  request a frame; accepted only when ready=1.
REQ-009 data_in  in  N_CH*DATA_W  channel k sample at bits [k*DATA_W +: DATA_W].
REQ-010 pd_mode  in  2  power-down code (present only with PMOD_DAC_PD_EN).
REQ-011 ready  out  1  idle, able to accept start.
REQ-012 done  out  1  one-cycle pulse at frame completion.
REQ-013 cs  out  1  active-low chip select shared by all channels.
REQ-014 sclk  out  1  serial clock, idles high.
REQ-015 din  out  N_CH  serial data, bit k drives channel k.

Function
REQ-016 FRAME_W SHALL equal LEAD_BITS+DATA_W; frame is MSB first: LEAD_BITS control bits then sample MSB..LSB.
REQ-017 Accept: at the edge where start=1 and ready=1, block SHALL latch all data_in (and pd_mode), drop ready, enter SHIFT; later data_in changes SHALL not affect the frame.
REQ-018 States SHALL be IDLE -> SHIFT -> GAP -> IDLE; no other states.
REQ-019 SHIFT: from accept edge, cs=0; each bit occupies 2*CLK_DIV cycles: first CLK_DIV cycles sclk=1, next CLK_DIV cycles sclk=0; din changes only when sclk goes high.
REQ-020 SHIFT SHALL last exactly FRAME_W*2*CLK_DIV cycles; at its end cs=1, sclk=1, din=0, enter GAP.
REQ-021 GAP SHALL last GAP_CYC cycles; on its final edge done=1 for one cycle and ready=1.
REQ-022 Latency accept-edge to done-edge SHALL be FRAME_W*2*CLK_DIV+GAP_CYC cycles (33 at defaults).
REQ-023 start while ready=0 SHALL be ignored, not queued.
REQ-024 start high in the cycle done is high SHALL be accepted (back-to-back, minimum cs-high time GAP_CYC).
REQ-025 start held high continuously SHALL produce back-to-back frames.
REQ-026 IDLE outputs: cs=1, sclk=1, din=0, ready=1, done=0.
REQ-027 Bit counter SHALL be sized for FRAME_W; divider counter for CLK_DIV; no wrap beyond FRAME_W.

Reset
REQ-028 rst=1 SHALL, at the next edge, force IDLE: cs=1, sclk=1, din=0, ready=1, done=0, counters 0.
REQ-029 rst mid-frame SHALL abort the frame without a done pulse; rst dominates a simultaneous start.
REQ-030 First start after rst release SHALL be accepted on the first edge with rst=0.

Configuration
REQ-031 Macro PMOD_DAC_PD_EN defined: pd_mode port exists; lead bits LEAD_BITS-2 and LEAD_BITS-1 (last two before data) carry pd_mode[1] then pd_mode[0], latched at accept; LEAD_BITS<2 SHALL be a elaboration error.
REQ-032 Macro undefined: no pd_mode port; all lead bits are 0.

Verification
REQ-033 Defaults, data_in={12'hA5C,12'h3F1}, one start -> din[0] shows 0000_0011_1111_0001, din[1] 0000_1010_0101_1100, 16 sclk falls, cs low 32 cycles, done 33 cycles after accept.
REQ-034 CLK_DIV=3, N_CH=4, DATA_W=8 -> sclk high 3/low 3, cs low 72 cycles, all four lanes correct.
REQ-035 start held high 3 frames -> cs high exactly GAP_CYC cycles between frames, 3 done pulses.
REQ-036 start pulsed mid-frame and data_in changed mid-frame -> ignored; transmitted frame unchanged.
REQ-037 rst asserted at bit 7 -> next edge cs=1, sclk=1, din=0, ready=1, no done.
REQ-038 PMOD_DAC_PD_EN, pd_mode=2'b10 -> frame bits 15..12 = 0,0,1,0.
